// File: rtl/mul_csv_rr_sched.sv
// mul_csv_rr_sched: round-robin scheduler sharing one carry-save multiplier among NumReq requesters.
// Latency: 2 cycles from request handshake to rsp_valid_o; one request per cycle sustained.
// Backpressure: rsp_ready_i low stalls R, then O; requester ready bits drop once O cannot advance.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   req_valid_i / req_ready_o       per-requester handshake (ready is one-hot or zero)
//   req_xs_i, req_xc_i, req_y_i     packed per-requester operands, requester i at slice i
//   rsp_valid_o / rsp_ready_i       response handshake
//   rsp_id_o, rsp_ps_o, rsp_pc_o    owning requester and carry-save product
//   rsp_ovf_o                       XS+XC carried out of WidthX bits

// MulCsvUns: unsigned (XS+XC)*Y returned in carry-save form (PS+PC = product mod 2^(WidthX+WidthY)).
// Latency: combinational.
// Backpressure: none.
//
// Ports: i_xs, i_xc (carry-save multiplier), i_y (multiplicand), o_ps/o_pc (carry-save product).
// Speed==0 reduces every partial product through one CSA chain; Speed!=0 reduces the XS and XC
// partial products in two parallel chains merged by a final 4:2 step, roughly halving the depth.
module MulCsvUns #(
  parameter int WidthX = 8,
  parameter int WidthY = 8,
  parameter int Speed  = 2
) (
  input  logic [WidthX-1:0]        i_xs,
  input  logic [WidthX-1:0]        i_xc,
  input  logic [WidthY-1:0]        i_y,
  output logic [WidthX+WidthY-1:0] o_ps,
  output logic [WidthX+WidthY-1:0] o_pc
);

  localparam int PW = WidthX + WidthY;

  // 3:2 compressor; returns {sum, carry} with the carry already shifted into weight position.
  function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] a,
                                          input logic [PW-1:0] b,
                                          input logic [PW-1:0] c);
    logic [PW-1:0] s;
    logic [PW-1:0] m;
    s = a ^ b ^ c;
    m = (a & b) | (a & c) | (b & c);
    return {s, m << 1};
  endfunction

  always_comb begin
    logic [PW-1:0]   s_a;
    logic [PW-1:0]   c_a;
    logic [PW-1:0]   s_b;
    logic [PW-1:0]   c_b;
    logic [PW-1:0]   pp;
    logic [2*PW-1:0] t;
    s_a = '0;
    c_a = '0;
    s_b = '0;
    c_b = '0;
    pp  = '0;
    t   = '0;
    for (int i = 0; i < WidthX; i++) begin
      pp  = i_xs[i] ? (PW'(i_y) << i) : '0;
      t   = csa(s_a, c_a, pp);
      s_a = t[2*PW-1:PW];
      c_a = t[PW-1:0];
      pp  = i_xc[i] ? (PW'(i_y) << i) : '0;
      if (Speed == 0) begin
        t   = csa(s_a, c_a, pp);
        s_a = t[2*PW-1:PW];
        c_a = t[PW-1:0];
      end else begin
        t   = csa(s_b, c_b, pp);
        s_b = t[2*PW-1:PW];
        c_b = t[PW-1:0];
      end
    end
    if (Speed != 0) begin
      t   = csa(s_a, c_a, s_b);
      s_a = t[2*PW-1:PW];
      c_a = t[PW-1:0];
      t   = csa(s_a, c_a, c_b);
      s_a = t[2*PW-1:PW];
      c_a = t[PW-1:0];
    end
    o_ps = s_a;
    o_pc = c_a;
  end

endmodule

module mul_csv_rr_sched #(
  parameter  int WidthX = 8,
  parameter  int WidthY = 8,
  parameter  int NumReq = 4,
  parameter  int Speed  = 2,
  localparam int IdW    = $clog2(NumReq)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumReq-1:0]          req_valid_i,
  output logic [NumReq-1:0]          req_ready_o,
  input  logic [NumReq*WidthX-1:0]   req_xs_i,
  input  logic [NumReq*WidthX-1:0]   req_xc_i,
  input  logic [NumReq*WidthY-1:0]   req_y_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [IdW-1:0]             rsp_id_o,
  output logic [WidthX+WidthY-1:0]   rsp_ps_o,
  output logic [WidthX+WidthY-1:0]   rsp_pc_o,
  output logic                       rsp_ovf_o
);

  localparam int PW = WidthX + WidthY;

  // Round-robin pointer
  logic [IdW-1:0]    r_ptr;

  // Stage O: registered operands feeding the multiplier
  logic              r_op_vld;
  logic [IdW-1:0]    r_op_id;
  logic [WidthX-1:0] r_op_xs;
  logic [WidthX-1:0] r_op_xc;
  logic [WidthY-1:0] r_op_y;
  logic              r_op_ovf;

  // Stage R: registered product, drives the response port directly
  logic              r_res_vld;
  logic [IdW-1:0]    r_res_id;
  logic [PW-1:0]     r_res_ps;
  logic [PW-1:0]     r_res_pc;
  logic              r_res_ovf;

  logic              w_r_adv;
  logic              w_o_adv;
  logic              w_any_vld;
  logic              w_hs;
  logic [IdW-1:0]    w_gnt_id;
  logic [WidthX-1:0] w_xs;
  logic [WidthX-1:0] w_xc;
  logic [WidthY-1:0] w_y;
  logic              w_ovf;
  logic [PW-1:0]     w_ps;
  logic [PW-1:0]     w_pc;

  // R frees up when empty or being consumed this cycle; O frees up when R can take its content.
  assign w_r_adv = !r_res_vld || rsp_ready_i;
  assign w_o_adv = !r_op_vld || w_r_adv;

  // Search ptr, ptr+1, ... (mod NumReq); iterating from the far end lets the nearest valid win.
  always_comb begin
    logic [IdW:0] idx;
    w_any_vld = 1'b0;
    w_gnt_id  = '0;
    idx       = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      idx = {1'b0, r_ptr} + (IdW+1)'(k);
      if (idx >= (IdW+1)'(NumReq)) begin
        idx = idx - (IdW+1)'(NumReq);
      end
      if (req_valid_i[idx[IdW-1:0]]) begin
        w_any_vld = 1'b1;
        w_gnt_id  = idx[IdW-1:0];
      end
    end
  end

  // Reset gating keeps every ready bit low while rst_i is asserted.
  assign w_hs        = w_any_vld && w_o_adv && !rst_i;
  assign req_ready_o = w_hs ? (NumReq'(1) << w_gnt_id) : '0;

  always_comb begin
    w_xs = '0;
    w_xc = '0;
    w_y  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (w_gnt_id == IdW'(i)) begin
        w_xs = req_xs_i[i*WidthX +: WidthX];
        w_xc = req_xc_i[i*WidthX +: WidthX];
        w_y  = req_y_i[i*WidthY +: WidthY];
      end
    end
  end

  // Carry out of XS+XC at WidthX bits.
  assign w_ovf = 1'(({1'b0, w_xs} + {1'b0, w_xc}) >> WidthX);

  MulCsvUns #(
    .WidthX (WidthX),
    .WidthY (WidthY),
    .Speed  (Speed)
  ) u_mul (
    .i_xs (r_op_xs),
    .i_xc (r_op_xc),
    .i_y  (r_op_y),
    .o_ps (w_ps),
    .o_pc (w_pc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr     <= '0;
      r_op_vld  <= 1'b0;
      r_op_id   <= '0;
      r_op_xs   <= '0;
      r_op_xc   <= '0;
      r_op_y    <= '0;
      r_op_ovf  <= 1'b0;
      r_res_vld <= 1'b0;
      r_res_id  <= '0;
      r_res_ps  <= '0;
      r_res_pc  <= '0;
      r_res_ovf <= 1'b0;
    end else begin
      if (w_o_adv) begin
        r_op_vld <= w_hs;
        if (w_hs) begin
          r_op_id  <= w_gnt_id;
          r_op_xs  <= w_xs;
          r_op_xc  <= w_xc;
          r_op_y   <= w_y;
          r_op_ovf <= w_ovf;
          r_ptr    <= (w_gnt_id == IdW'(NumReq - 1)) ? '0 : w_gnt_id + 1'b1;
        end
      end
      // Loading R on the same edge a response is consumed gives bubble-free throughput.
      if (w_r_adv) begin
        r_res_vld <= r_op_vld;
        r_res_id  <= r_op_id;
        r_res_ps  <= w_ps;
        r_res_pc  <= w_pc;
        r_res_ovf <= r_op_ovf;
      end
    end
  end

  assign rsp_valid_o = r_res_vld;
  assign rsp_id_o    = r_res_id;
  assign rsp_ps_o    = r_res_ps;
  assign rsp_pc_o    = r_res_pc;
  assign rsp_ovf_o   = r_res_ovf;

endmodule

// File: tb/tb_mul_csv_rr_sched.sv
// tb_mul_csv_rr_sched: directed bench for mul_csv_rr_sched with a response scoreboard.
// Inputs change 1 time unit after the rising edge; comparisons happen 2 units after it,
// and the response monitor samples handshakes on the falling edge.
module tb_mul_csv_rr_sched;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  vld;
  logic [3:0]  rdy;
  logic [7:0]  t_xs [4];
  logic [7:0]  t_xc [4];
  logic [7:0]  t_y  [4];
  logic [31:0] xs_bus;
  logic [31:0] xc_bus;
  logic [31:0] y_bus;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_ps;
  logic [15:0] rsp_pc;
  logic        rsp_ovf;

  always_comb begin
    xs_bus = '0;
    xc_bus = '0;
    y_bus  = '0;
    for (int i = 0; i < 4; i++) begin
      xs_bus[i*8 +: 8] = t_xs[i];
      xc_bus[i*8 +: 8] = t_xc[i];
      y_bus[i*8 +: 8]  = t_y[i];
    end
  end

  mul_csv_rr_sched #(
    .WidthX (8),
    .WidthY (8),
    .NumReq (4),
    .Speed  (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (vld),
    .req_ready_o (rdy),
    .req_xs_i    (xs_bus),
    .req_xc_i    (xc_bus),
    .req_y_i     (y_bus),
    .rsp_valid_o (rsp_vld),
    .rsp_ready_i (rsp_rdy),
    .rsp_id_o    (rsp_id),
    .rsp_ps_o    (rsp_ps),
    .rsp_pc_o    (rsp_pc),
    .rsp_ovf_o   (rsp_ovf)
  );

  int          checks = 0;
  int          fails  = 0;
  logic [18:0] exp_q [$];   // {id[1:0], ovf, sum[15:0]}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    t_xs[i] = a;
    t_xc[i] = b;
    t_y[i]  = c;
  endtask

  task automatic push_raw(input logic [1:0] id, input logic [15:0] sum, input logic o);
    exp_q.push_back({id, o, sum});
  endtask

  task automatic push_ops(input logic [1:0] id, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    int x;
    int p;
    x = int'(a) + int'(b);
    p = x * int'(c);
    push_raw(id, p[15:0], x > 255);
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_vld) && n < 20) begin
      tick;
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Scoreboard: every accepted response must match the next expected entry.
  logic [15:0] mon_sum;
  logic [18:0] mon_e;
  always @(negedge clk) begin
    if (!rst && rsp_vld && rsp_rdy) begin
      mon_sum = rsp_ps + rsp_pc;
      if (exp_q.size() == 0) begin
        chk("rsp_extra", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", rsp_id, mon_e[18:17]);
        chk("rsp_sum", mon_sum, mon_e[15:0]);
        chk("rsp_ovf", rsp_ovf, mon_e[16]);
      end
    end
  end

  logic [15:0] h_ps;
  logic [15:0] h_pc;

  initial begin
    rst     = 1'b1;
    vld     = 4'hF;
    rsp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) set_ops(i, 8'd0, 8'd0, 8'd0);

    // Reset state, with all valids asserted
    tick;
    tick;
    #1;
    chk("rst_rdy", rdy, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_ps", rsp_ps, 0);
    chk("rst_rsp_pc", rsp_pc, 0);
    chk("rst_rsp_ovf", rsp_ovf, 0);
    tick;

    // Full contention from ptr=0: grants 0,1,2,3,0,... back to back
    for (int i = 0; i < 4; i++) set_ops(i, 8'(i + 1), 8'(2 * i), 8'(10 + i));
    rst = 1'b0;
    vld = 4'hF;
    for (int k = 0; k < 8; k++) begin
      int g;
      g = k % 4;
      #1;
      chk("cont_rdy", rdy, 1 << g);
      if (k >= 2) begin
        chk("cont_rsp_vld", rsp_vld, 1);
        chk("cont_rsp_id", rsp_id, (k - 2) % 4);
      end
      push_ops(2'(g), t_xs[g], t_xc[g], t_y[g]);
      tick;
      t_xs[g] = t_xs[g] + 8'd3;
      t_y[g]  = t_y[g] + 8'd1;
    end
    vld = 4'h0;
    wait_idle;

    // Single request from requester 2: (3+4)*5 = 35 two edges later
    set_ops(2, 8'd3, 8'd4, 8'd5);
    vld = 4'b0100;
    #1;
    chk("single_rdy", rdy, 4'b0100);
    push_raw(2'd2, 16'd35, 1'b0);
    tick;
    vld = 4'h0;
    #1;
    chk("single_lat1_vld", rsp_vld, 0);
    tick;
    #1;
    chk("single_vld", rsp_vld, 1);
    chk("single_id", rsp_id, 2);
    wait_idle;

    // Wrap from ptr=3: grant 3, then 0, then ptr=1 makes requester 1 win over 0 and 3
    set_ops(3, 8'd7, 8'd1, 8'd9);
    set_ops(0, 8'd2, 8'd2, 8'd3);
    vld = 4'b1001;
    #1;
    chk("wrap_rdy3", rdy, 4'b1000);
    push_raw(2'd3, 16'd72, 1'b0);
    tick;
    set_ops(3, 8'd1, 8'd1, 8'd1);
    #1;
    chk("wrap_rdy0", rdy, 4'b0001);
    push_raw(2'd0, 16'd12, 1'b0);
    tick;
    set_ops(1, 8'd5, 8'd0, 8'd6);
    vld = 4'b1011;
    #1;
    chk("wrap_ptr1", rdy, 4'b0010);
    push_raw(2'd1, 16'd30, 1'b0);
    tick;
    vld = 4'h0;
    wait_idle;

    // Overflow: 200+100 exceeds 8 bits, product 300 still delivered
    set_ops(2, 8'd200, 8'd100, 8'd1);
    vld = 4'b0100;
    #1;
    chk("ovf_rdy", rdy, 4'b0100);
    push_raw(2'd2, 16'd300, 1'b1);
    tick;
    vld = 4'h0;
    wait_idle;

    // Backpressure from ptr=3: requests 3 and 0 fill both stages, 1 waits
    rsp_rdy = 1'b0;
    set_ops(3, 8'd10, 8'd5, 8'd2);
    set_ops(0, 8'd6, 8'd6, 8'd6);
    set_ops(1, 8'd255, 8'd255, 8'd255);
    vld = 4'b1011;
    #1;
    chk("bp_rdy_a", rdy, 4'b1000);
    push_raw(2'd3, 16'd30, 1'b0);
    tick;
    vld = 4'b0011;
    #1;
    chk("bp_rdy_b", rdy, 4'b0001);
    push_raw(2'd0, 16'd72, 1'b0);
    tick;
    vld = 4'b0010;
    #1;
    h_ps = rsp_ps;
    h_pc = rsp_pc;
    for (int s = 0; s < 5; s++) begin
      if (s != 0) #1;
      chk("bp_stall_rdy", rdy, 0);
      chk("bp_hold_vld", rsp_vld, 1);
      chk("bp_hold_id", rsp_id, 3);
      chk("bp_hold_sum", 16'(rsp_ps + rsp_pc), 30);
      chk("bp_hold_ps", rsp_ps, h_ps);
      chk("bp_hold_pc", rsp_pc, h_pc);
      tick;
    end
    rsp_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", rdy, 4'b0010);
    push_raw(2'd1, 16'd64514, 1'b1);   // 510*255 = 130050, mod 65536
    tick;
    vld = 4'h0;
    wait_idle;

    // Reset mid-flight: ptr=2, fill O and R with requests 2 and 1, then reset
    rsp_rdy = 1'b0;
    set_ops(2, 8'd1, 8'd1, 8'd1);
    set_ops(1, 8'd2, 8'd2, 8'd2);
    vld = 4'b0100;
    #1;
    chk("mrst_fill_a", rdy, 4'b0100);
    tick;
    vld = 4'b0010;
    #1;
    chk("mrst_fill_b", rdy, 4'b0010);
    tick;
    vld = 4'h0;
    #1;
    chk("mrst_full", rsp_vld, 1);
    tick;
    rst = 1'b1;
    vld = 4'b0001;
    #1;
    chk("mrst_rdy_in_rst", rdy, 0);
    tick;
    rst = 1'b0;
    rsp_rdy = 1'b1;
    set_ops(0, 8'd9, 8'd0, 8'd9);
    set_ops(2, 8'd4, 8'd4, 8'd4);
    vld = 4'b0101;
    #1;
    chk("mrst_rsp_vld", rsp_vld, 0);
    chk("mrst_ptr0", rdy, 4'b0001);
    push_raw(2'd0, 16'd81, 1'b0);
    tick;
    vld = 4'h0;
    wait_idle;
    tick;
    #1;
    chk("end_idle", rsp_vld, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
